// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between mem (priority) and ex,
// with a bounded-wait counter for ex and combinational hazard queries for decode.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [4:0]       mem_addr,
    input  logic [31:0]      mem_data,
    output logic             mem_ready,
    input  logic             ex_valid,
    input  logic [4:0]       ex_addr,
    input  logic [31:0]      ex_data,
    output logic             ex_ready,
    output logic [4:0]       wa,
    output logic [31:0]      wn,
    output logic             we,
    input  logic [4:0]       q_addr1,
    output logic             q_hit1,
    input  logic [4:0]       q_addr2,
    output logic             q_hit2,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]       wait_cnt_reg;
    logic [4:0]       wa_reg;
    logic [31:0]      wn_reg;
    logic             we_reg;
    logic [CNT_W-1:0] conflict_cnt_reg;

    logic             ex_forced;
    logic             grant_mem;
    logic             grant_ex;
    logic             mem_accept;
    logic             ex_accept;
    logic             both_valid;

    // ex wins a conflict only once it has been refused STARVE_LIMIT cycles in a row
    assign both_valid = mem_valid && ex_valid;
    assign ex_forced  = (wait_cnt_reg == LIMIT);
    assign grant_mem  = rst && mem_valid && !(ex_valid && ex_forced);
    assign grant_ex   = rst && ex_valid && (!mem_valid || ex_forced);

    assign mem_ready  = grant_mem;
    assign ex_ready   = grant_ex;
    assign mem_accept = mem_valid && grant_mem;
    assign ex_accept  = ex_valid && grant_ex;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_reg     <= '0;
            wa_reg           <= '0;
            wn_reg           <= '0;
            we_reg           <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            if (!ex_valid || ex_accept)
                wait_cnt_reg <= '0;
            else if (wait_cnt_reg != LIMIT)
                wait_cnt_reg <= wait_cnt_reg + 4'd1;

            // Writes to x0 are consumed but never enabled onto the port
            if (mem_accept) begin
                wa_reg <= mem_addr;
                wn_reg <= mem_data;
                we_reg <= (mem_addr != 5'd0);
            end else if (ex_accept) begin
                wa_reg <= ex_addr;
                wn_reg <= ex_data;
                we_reg <= (ex_addr != 5'd0);
            end else begin
                we_reg <= 1'b0;
            end

            if (both_valid && (conflict_cnt_reg != {CNT_W{1'b1}}))
                conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
        end
    end

    assign wa           = wa_reg;
    assign wn           = wn_reg;
    assign we           = we_reg;
    assign conflict_cnt = conflict_cnt_reg;

    // The registered output write is left out: the register file forwards it itself
    logic [4:0] q_addr [2];
    logic [1:0] q_hit;

    assign q_addr[0] = q_addr1;
    assign q_addr[1] = q_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            assign q_hit[gi] = (q_addr[gi] != 5'd0) &&
                               ((mem_valid && (mem_addr == q_addr[gi])) ||
                                (ex_valid && (ex_addr == q_addr[gi])));
        end
    endgenerate

    assign q_hit1 = q_hit[0];
    assign q_hit2 = q_hit[1];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; a second instance with CNT_W=4
// shares the inputs to exercise conflict counter saturation.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        ex_valid;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;

    logic        mem_ready, ex_ready, we, q_hit1, q_hit2;
    logic [4:0]  wa;
    logic [31:0] wn;
    logic [15:0] conflict_cnt;

    logic        s_mem_ready, s_ex_ready, s_we, s_q_hit1, s_q_hit2;
    logic [4:0]  s_wa;
    logic [31:0] s_wn;
    logic [3:0]  s_conflict_cnt;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(ex_ready),
        .wa(wa), .wn(wn), .we(we),
        .q_addr1(q_addr1), .q_hit1(q_hit1), .q_addr2(q_addr2), .q_hit2(q_hit2),
        .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(s_mem_ready),
        .ex_valid(ex_valid), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ready(s_ex_ready),
        .wa(s_wa), .wn(s_wn), .we(s_we),
        .q_addr1(q_addr1), .q_hit1(s_q_hit1), .q_addr2(q_addr2), .q_hit2(s_q_hit2),
        .conflict_cnt(s_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h1111_1111;
        ex_valid = 1'b1;  ex_addr = 5'd4;  ex_data = 32'h2222_2222;
        q_addr1 = 5'd0; q_addr2 = 5'd0;
        tick();
        tick();
        checks++;
        if (mem_ready !== 1'b0 || ex_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: mem_ready=%b ex_ready=%b expected 0 0", mem_ready, ex_ready);
        end
        checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wn !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b wa=%0d wn=%h expected 0 0 0", we, wa, wn);
        end
        checks++;
        if (conflict_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_conflict: conflict_cnt=%0d expected 0", conflict_cnt);
        end
        $display("reset: we=%b wa=%0d wn=%h conflict_cnt=%0d", we, wa, wn, conflict_cnt);
        mem_valid = 1'b0; ex_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_source();
        ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: ex_ready=%b mem_ready=%b expected 1 0", ex_ready, mem_ready);
        end
        tick();
        ex_valid = 1'b0;
        checks++;
        if (we !== 1'b1 || wa !== 5'd5 || wn !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: we=%b wa=%0d wn=%h expected 1 5 deadbeef", we, wa, wn);
        end
        $display("single: we=%b wa=%0d wn=%h", we, wa, wn);
        tick();
        checks++;
        if (we !== 1'b0 || wa !== 5'd5 || wn !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_hold: we=%b wa=%0d wn=%h expected 0 5 deadbeef", we, wa, wn);
        end
    endtask

    task automatic test_starvation();
        int mem_idx;
        logic exp_ex;
        logic [4:0] exp_wa;
        mem_idx = 1;
        ex_valid = 1'b1; ex_addr = 5'd20; ex_data = 32'hE0E0_0000;
        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1;
            mem_addr = 5'(mem_idx);
            mem_data = 32'hA000_0000 + 32'(mem_idx);
            exp_ex = (i == 3) || (i == 7);
            #1;
            checks++;
            if (ex_ready !== exp_ex || mem_ready !== !exp_ex) begin
                errors++;
                $display("FAIL starve_grant[%0d]: mem_ready=%b ex_ready=%b expected %b %b",
                         i, mem_ready, ex_ready, !exp_ex, exp_ex);
            end
            exp_wa = exp_ex ? 5'd20 : 5'(mem_idx);
            tick();
            checks++;
            if (we !== 1'b1 || wa !== exp_wa) begin
                errors++;
                $display("FAIL starve_write[%0d]: we=%b wa=%0d expected 1 %0d", i, we, wa, exp_wa);
            end
            $display("starve cycle %0d: winner=%s wa=%0d wn=%h", i, exp_ex ? "ex" : "mem", wa, wn);
            if (!exp_ex) mem_idx++;
        end
        checks++;
        if (conflict_cnt !== 16'd8) begin
            errors++;
            $display("FAIL starve_conflict: conflict_cnt=%0d expected 8", conflict_cnt);
        end
        mem_valid = 1'b0; ex_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_write();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h0000_1234;
        q_addr1 = 5'd0;
        #1;
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: mem_ready=%b expected 1", mem_ready);
        end
        checks++;
        if (q_hit1 !== 1'b0) begin
            errors++;
            $display("FAIL x0_query: q_hit1=%b expected 0", q_hit1);
        end
        tick();
        mem_valid = 1'b0;
        checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wn !== 32'h0000_1234) begin
            errors++;
            $display("FAIL x0_write: we=%b wa=%0d wn=%h expected 0 0 00001234", we, wa, wn);
        end
        $display("x0: we=%b wa=%0d wn=%h", we, wa, wn);
    endtask

    task automatic test_hazard();
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h7777_7777;
        ex_valid = 1'b1;  ex_addr = 5'd9;  ex_data = 32'h9999_9999;
        q_addr1 = 5'd9; q_addr2 = 5'd4;
        #1;
        checks++;
        if (q_hit1 !== 1'b1 || q_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_query: q_hit1=%b q_hit2=%b expected 1 0", q_hit1, q_hit2);
        end
        q_addr2 = 5'd7;
        #1;
        checks++;
        if (q_hit2 !== 1'b1) begin
            errors++;
            $display("FAIL hazard_mem_query: q_hit2=%b expected 1", q_hit2);
        end
        // Wait counter was cleared by the idle cycles, so ex wins on the 4th conflict cycle
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ex_ready !== (i == 3)) begin
                errors++;
                $display("FAIL hazard_grant[%0d]: ex_ready=%b expected %b", i, ex_ready, (i == 3));
            end
            tick();
        end
        ex_valid = 1'b0; mem_valid = 1'b0;
        #1;
        checks++;
        if (we !== 1'b1 || wa !== 5'd9 || wn !== 32'h9999_9999) begin
            errors++;
            $display("FAIL hazard_ex_write: we=%b wa=%0d wn=%h expected 1 9 99999999", we, wa, wn);
        end
        checks++;
        if (q_hit1 !== 1'b0 || q_hit2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_cleared: q_hit1=%b q_hit2=%b expected 0 0", q_hit1, q_hit2);
        end
        $display("hazard: ex write wa=%0d wn=%h q_hit1=%b", wa, wn, q_hit1);
        checks++;
        if (conflict_cnt !== 16'd12) begin
            errors++;
            $display("FAIL hazard_conflict: conflict_cnt=%0d expected 12", conflict_cnt);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hBBBB_0000;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: mem_ready=%b expected 0", mem_ready);
        end
        tick();
        checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wn !== 32'd0 || s_conflict_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midreset_outputs: we=%b wa=%0d wn=%h sat_cnt=%0d expected 0 0 0 0",
                     we, wa, wn, s_conflict_cnt);
        end
        $display("mid reset: we=%b wa=%0d wn=%h", we, wa, wn);
        mem_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'h1;
        ex_valid = 1'b1;  ex_addr = 5'd2;  ex_data = 32'h2;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (s_conflict_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_conflict: conflict_cnt=%0d expected 15", s_conflict_cnt);
        end
        checks++;
        if (conflict_cnt !== 16'd20) begin
            errors++;
            $display("FAIL wide_conflict: conflict_cnt=%0d expected 20", conflict_cnt);
        end
        tick();
        checks++;
        if (s_conflict_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: conflict_cnt=%0d expected 15", s_conflict_cnt);
        end
        $display("saturation: cnt4=%0d cnt16=%0d", s_conflict_cnt, conflict_cnt);
        mem_valid = 1'b0; ex_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_starvation();
        test_x0_write();
        test_hazard();
        test_mid_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
